// File: rtl/mcp02_stack_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mcp02_stack_alu_unit
// Description : Operand stack with an integrated ALU for the multicycle stack
//               processor. Commands arrive one at a time over a valid/ready
//               handshake. Each command is sequenced over several cycles
//               against a single-port storage array. The unit exports TOS, a
//               zero flag and occupancy status as registered outputs.
// Options     : MCP02_DUP_SWAP_EN - when defined, DUP and SWAP are built in;
//               otherwise opcodes 110/111 complete as one-cycle errors.
// Revision    : 1.0 - initial release
// ============================================================================
module mcp02_stack_alu_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          tos,
    output logic                       zero,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    localparam logic [2:0] c_OP_PUSH = 3'b000;
    localparam logic [2:0] c_OP_POP  = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_NOT  = 3'b101;
    localparam logic [2:0] c_OP_DUP  = 3'b110;
    localparam logic [2:0] c_OP_SWAP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WR   = 3'd4,
`ifdef MCP02_DUP_SWAP_EN
        S_WR2  = 3'd5,
`endif
        S_DONE = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W-1:0]   r_res;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_nxt_count;
    logic [DATA_W-1:0]   r_tos;
    logic [DATA_W-1:0]   r_nxt_tos;
    logic                r_zero;
    logic                r_full;
    logic                r_empty;

    logic                w_accept;
    logic                w_err;
    logic [DATA_W-1:0]   w_alu;
    logic [c_ADDR_W-1:0] w_sp;
    logic [c_ADDR_W-1:0] w_tos_a;
    logic [c_ADDR_W-1:0] w_nos_a;
    logic [c_ADDR_W-1:0] w_addr;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);

    // Addresses wrap in c_ADDR_W bits, so sp == DEPTH maps to 0 and
    // sp-1 / sp-2 still land on the right entries when the stack is full.
    assign w_sp      = r_count[c_ADDR_W-1:0];
    assign w_tos_a   = w_sp - c_ADDR_W'(1);
    assign w_nos_a   = w_sp - c_ADDR_W'(2);
    assign w_rd_data = r_mem[w_addr];

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_err   = (r_state == S_DONE) && r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign tos       = r_tos;
    assign zero      = r_zero;
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;

    // Reject a command at accept time if the stack cannot support it.
    always_comb begin
        w_err = 1'b0;
        case (cmd_op)
            c_OP_PUSH:                    w_err = r_full;
            c_OP_POP, c_OP_NOT:           w_err = r_empty;
            c_OP_ADD, c_OP_SUB, c_OP_AND: w_err = (r_count < c_CNT_W'(2));
`ifdef MCP02_DUP_SWAP_EN
            c_OP_DUP:                     w_err = r_empty || r_full;
            c_OP_SWAP:                    w_err = (r_count < c_CNT_W'(2));
`else
            c_OP_DUP, c_OP_SWAP:          w_err = 1'b1;
`endif
            default:                      w_err = 1'b1;
        endcase
    end

    // ALU: NOS is the left operand, so SUB yields NOS - TOS.
    always_comb begin
        w_alu = '0;
        case (r_op)
            c_OP_ADD: w_alu = r_opb + r_opa;
            c_OP_SUB: w_alu = r_opb - r_opa;
            c_OP_AND: w_alu = r_opb & r_opa;
            c_OP_NOT: w_alu = ~r_opa;
            default:  w_alu = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and single-port storage address/write control.
    always_comb begin
        w_state_nxt = r_state;
        w_addr      = w_tos_a;
        w_we        = 1'b0;
        w_wdata     = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = S_DONE;
                    end else if (cmd_op == c_OP_PUSH) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                // POP already holds the popped value in r_tos; its one read
                // fetches the entry that becomes the new TOS.
                w_addr = (r_op == c_OP_POP) ? w_nos_a : w_tos_a;
                case (r_op)
                    c_OP_POP: w_state_nxt = S_DONE;
                    c_OP_NOT: w_state_nxt = S_EXEC;
`ifdef MCP02_DUP_SWAP_EN
                    c_OP_DUP: w_state_nxt = S_WR;
`endif
                    default:  w_state_nxt = S_RD_B;
                endcase
            end
            S_RD_B: begin
                w_addr = w_nos_a;
`ifdef MCP02_DUP_SWAP_EN
                w_state_nxt = (r_op == c_OP_SWAP) ? S_WR : S_EXEC;
`else
                w_state_nxt = S_EXEC;
`endif
            end
            S_EXEC: begin
                w_state_nxt = S_WR;
            end
            S_WR: begin
                w_we        = 1'b1;
                w_state_nxt = S_DONE;
                case (r_op)
                    c_OP_PUSH: begin
                        w_addr  = w_sp;
                        w_wdata = r_data;
                    end
                    c_OP_NOT: begin
                        w_addr  = w_tos_a;
                        w_wdata = r_res;
                    end
`ifdef MCP02_DUP_SWAP_EN
                    c_OP_DUP: begin
                        w_addr  = w_sp;
                        w_wdata = r_opa;
                    end
                    c_OP_SWAP: begin
                        w_addr      = w_nos_a;
                        w_wdata     = r_opa;
                        w_state_nxt = S_WR2;
                    end
`endif
                    default: begin
                        w_addr  = w_nos_a;
                        w_wdata = r_res;
                    end
                endcase
            end
`ifdef MCP02_DUP_SWAP_EN
            S_WR2: begin
                w_we        = 1'b1;
                w_addr      = w_tos_a;
                w_wdata     = r_opb;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Storage array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    // Operand capture, response build-up and status commit on DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= c_OP_PUSH;
            r_data      <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_res       <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_count     <= '0;
            r_nxt_count <= '0;
            r_tos       <= '0;
            r_nxt_tos   <= '0;
            r_zero      <= 1'b1;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= cmd_op;
                        r_data      <= cmd_data;
                        r_rsp_err   <= w_err;
                        r_rsp_data  <= '0;
                        r_nxt_count <= r_count;
                        r_nxt_tos   <= r_tos;
                    end
                end
                S_RD_A: begin
                    r_opa <= w_rd_data;
                    if (r_op == c_OP_POP) begin
                        r_nxt_count <= r_count - c_CNT_W'(1);
                        r_nxt_tos   <= (r_count >= c_CNT_W'(2)) ? w_rd_data : '0;
                        r_rsp_data  <= r_tos;
                    end
                end
                S_RD_B: begin
                    r_opb <= w_rd_data;
                end
                S_EXEC: begin
                    r_res <= w_alu;
                end
                S_WR: begin
                    case (r_op)
                        c_OP_PUSH: begin
                            r_nxt_count <= r_count + c_CNT_W'(1);
                            r_nxt_tos   <= r_data;
                            r_rsp_data  <= r_data;
                        end
                        c_OP_NOT: begin
                            r_nxt_tos  <= r_res;
                            r_rsp_data <= r_res;
                        end
                        c_OP_ADD, c_OP_SUB, c_OP_AND: begin
                            r_nxt_count <= r_count - c_CNT_W'(1);
                            r_nxt_tos   <= r_res;
                            r_rsp_data  <= r_res;
                        end
`ifdef MCP02_DUP_SWAP_EN
                        c_OP_DUP: begin
                            r_nxt_count <= r_count + c_CNT_W'(1);
                            r_nxt_tos   <= r_opa;
                            r_rsp_data  <= r_opa;
                        end
                        c_OP_SWAP: begin
                            r_nxt_tos  <= r_opb;
                            r_rsp_data <= r_opb;
                        end
`endif
                        default: begin
                        end
                    endcase
                end
                S_DONE: begin
                    r_count <= r_nxt_count;
                    r_tos   <= r_nxt_tos;
                    r_zero  <= (r_nxt_tos == '0);
                    r_full  <= (r_nxt_count == c_CNT_W'(DEPTH));
                    r_empty <= (r_nxt_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcp02_stack_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcp02_stack_alu_unit
// Description : Directed, table-driven bench for mcp02_stack_alu_unit
//               (DATA_W=8, DEPTH=16) with hand sequences for overflow and
//               reset in the middle of a command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp02_stack_alu_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    localparam logic [2:0] c_PUSH = 3'b000;
    localparam logic [2:0] c_POP  = 3'b001;
    localparam logic [2:0] c_ADD  = 3'b010;
    localparam logic [2:0] c_SUB  = 3'b011;
    localparam logic [2:0] c_AND  = 3'b100;
    localparam logic [2:0] c_NOT  = 3'b101;
    localparam logic [2:0] c_DUP  = 3'b110;
    localparam logic [2:0] c_SWAP = 3'b111;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [DATA_W-1:0] tos;
    logic              zero;
    logic [4:0]        count;
    logic              full;
    logic              empty;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         exp_count;
        logic [7:0] exp_tos;
    } vec_t;

    vec_t vecs[$];

    mcp02_stack_alu_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tos       (tos),
        .zero      (zero),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one command from a negedge; returns at the negedge where
    // rsp_valid is seen (or after a bounded wait).
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d,
                           output logic [7:0] rd, output logic re, output int lat);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready wait: got 0, expected 1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = ~d;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_data;
        re = rsp_err;
    endtask

    task automatic check_status(input string tag, input int exp_count, input logic [7:0] exp_tos);
        check({tag, " count"}, 32'(count), 32'(exp_count));
        check({tag, " tos"},   32'(tos),   32'(exp_tos));
        check({tag, " zero"},  32'(zero),  32'(exp_tos == 8'h00));
        check({tag, " empty"}, 32'(empty), 32'(exp_count == 0));
        check({tag, " full"},  32'(full),  32'(exp_count == DEPTH));
    endtask

    logic [7:0] got_d;
    logic       got_e;
    int         got_l;
    logic       seen_valid;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 8'h00;
        rst       = 1'b1;

        //                  op      data   rsp    err  lat cnt tos
        vecs.push_back('{c_PUSH, 8'h05, 8'h05, 1'b0, 2, 1, 8'h05});
        vecs.push_back('{c_PUSH, 8'h03, 8'h03, 1'b0, 2, 2, 8'h03});
        vecs.push_back('{c_SUB,  8'h00, 8'h02, 1'b0, 5, 1, 8'h02});
        vecs.push_back('{c_POP,  8'h00, 8'h02, 1'b0, 2, 0, 8'h00});
        vecs.push_back('{c_PUSH, 8'h02, 8'h02, 1'b0, 2, 1, 8'h02});
        vecs.push_back('{c_PUSH, 8'h05, 8'h05, 1'b0, 2, 2, 8'h05});
        vecs.push_back('{c_SUB,  8'h00, 8'hFD, 1'b0, 5, 1, 8'hFD});
        vecs.push_back('{c_NOT,  8'h00, 8'h02, 1'b0, 4, 1, 8'h02});
        vecs.push_back('{c_POP,  8'h00, 8'h02, 1'b0, 2, 0, 8'h00});
        vecs.push_back('{c_POP,  8'h00, 8'h00, 1'b1, 1, 0, 8'h00});
        vecs.push_back('{c_PUSH, 8'h80, 8'h80, 1'b0, 2, 1, 8'h80});
        vecs.push_back('{c_ADD,  8'h00, 8'h00, 1'b1, 1, 1, 8'h80});
        vecs.push_back('{c_PUSH, 8'h7F, 8'h7F, 1'b0, 2, 2, 8'h7F});
        vecs.push_back('{c_ADD,  8'h00, 8'hFF, 1'b0, 5, 1, 8'hFF});
        vecs.push_back('{c_PUSH, 8'h81, 8'h81, 1'b0, 2, 2, 8'h81});
        vecs.push_back('{c_ADD,  8'h00, 8'h80, 1'b0, 5, 1, 8'h80});
        vecs.push_back('{c_PUSH, 8'hC3, 8'hC3, 1'b0, 2, 2, 8'hC3});
        vecs.push_back('{c_AND,  8'h00, 8'h80, 1'b0, 5, 1, 8'h80});
        vecs.push_back('{c_SUB,  8'h00, 8'h00, 1'b1, 1, 1, 8'h80});
        vecs.push_back('{c_NOT,  8'h00, 8'h7F, 1'b0, 4, 1, 8'h7F});
        vecs.push_back('{c_POP,  8'h00, 8'h7F, 1'b0, 2, 0, 8'h00});
        vecs.push_back('{c_NOT,  8'h00, 8'h00, 1'b1, 1, 0, 8'h00});
        vecs.push_back('{c_DUP,  8'h00, 8'h00, 1'b1, 1, 0, 8'h00});
        vecs.push_back('{c_PUSH, 8'h01, 8'h01, 1'b0, 2, 1, 8'h01});
        vecs.push_back('{c_PUSH, 8'h02, 8'h02, 1'b0, 2, 2, 8'h02});
`ifdef MCP02_DUP_SWAP_EN
        vecs.push_back('{c_SWAP, 8'h00, 8'h01, 1'b0, 5, 2, 8'h01});
        vecs.push_back('{c_DUP,  8'h00, 8'h01, 1'b0, 3, 3, 8'h01});
        vecs.push_back('{c_POP,  8'h00, 8'h01, 1'b0, 2, 2, 8'h01});
        vecs.push_back('{c_POP,  8'h00, 8'h01, 1'b0, 2, 1, 8'h02});
`else
        vecs.push_back('{c_SWAP, 8'h00, 8'h00, 1'b1, 1, 2, 8'h02});
        vecs.push_back('{c_DUP,  8'h00, 8'h00, 1'b1, 1, 2, 8'h02});
        vecs.push_back('{c_POP,  8'h00, 8'h02, 1'b0, 2, 1, 8'h01});
`endif

        // Reset values.
        do_reset();
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err",   32'(rsp_err),   32'd0);
        check("reset rsp_data",  32'(rsp_data),  32'd0);
        check_status("reset", 0, 8'h00);

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            run_cmd(vecs[i].op, vecs[i].data, got_d, got_e, got_l);
            check($sformatf("v%0d rsp_data", i), 32'(got_d), 32'(vecs[i].exp_data));
            check($sformatf("v%0d rsp_err", i),  32'(got_e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i),  32'(got_l), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d ready_in_done", i), 32'(cmd_ready), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d rsp_pulse", i), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d ready_after", i), 32'(cmd_ready), 32'd1);
            check_status($sformatf("v%0d", i), vecs[i].exp_count, vecs[i].exp_tos);
        end

        // Overflow: fill with 1..DEPTH, then one PUSH too many.
        do_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            run_cmd(c_PUSH, 8'(k), got_d, got_e, got_l);
            check($sformatf("fill%0d rsp_err", k), 32'(got_e), 32'd0);
            @(negedge clk);
        end
        check_status("full", DEPTH, 8'(DEPTH));
        run_cmd(c_PUSH, 8'hAA, got_d, got_e, got_l);
        check("ovf rsp_err",  32'(got_e), 32'd1);
        check("ovf rsp_data", 32'(got_d), 32'd0);
        check("ovf latency",  32'(got_l), 32'd1);
        @(negedge clk);
        check_status("ovf", DEPTH, 8'(DEPTH));
        run_cmd(c_DUP, 8'h00, got_d, got_e, got_l);
        check("dup_full rsp_err", 32'(got_e), 32'd1);
        @(negedge clk);
        check_status("dup_full", DEPTH, 8'(DEPTH));
        run_cmd(c_POP, 8'h00, got_d, got_e, got_l);
        check("pop_full rsp_data", 32'(got_d), 32'(DEPTH));
        @(negedge clk);
        check_status("pop_full", DEPTH - 1, 8'(DEPTH - 1));

        // Reset while an ADD sits in RD_B.
        do_reset();
        run_cmd(c_PUSH, 8'h07, got_d, got_e, got_l);
        @(negedge clk);
        run_cmd(c_PUSH, 8'h09, got_d, got_e, got_l);
        @(negedge clk);
        check_status("pre_rst", 2, 8'h09);
        cmd_valid = 1'b1;
        cmd_op    = c_ADD;
        cmd_data  = 8'h00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rd_b cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst cmd_ready", 32'(cmd_ready), 32'd1);
        seen_valid = rsp_valid;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen_valid = seen_valid | rsp_valid;
        end
        check("post_rst no_rsp", 32'(seen_valid), 32'd0);
        check_status("post_rst", 0, 8'h00);
        run_cmd(c_PUSH, 8'h04, got_d, got_e, got_l);
        check("post_rst push data", 32'(got_d), 32'h04);
        @(negedge clk);
        check_status("post_rst push", 1, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
